// File: rtl/lcd_bus_monitor_if.sv
// HD44780-style 8-bit LCD bus as seen between an LCD writer and the monitor.
// Signals:
//   LCM_EN   - bus enable; a transaction completes on its falling edge
//   LCM_RS   - 0 = command, 1 = data
//   LCM_RW   - 0 = write, 1 = read
//   LCM_DATA - 8-bit bus data
// Modports: master drives the bus (LCD writer / bench), slave observes it.
interface lcd_bus_monitor_if;
  logic       LCM_EN;
  logic       LCM_RS;
  logic       LCM_RW;
  logic [7:0] LCM_DATA;

  modport master (output LCM_EN, LCM_RS, LCM_RW, LCM_DATA);
  modport slave  (input  LCM_EN, LCM_RS, LCM_RW, LCM_DATA);
endinterface

// File: rtl/lcd_bus_monitor.sv
// LCD bus monitor: decodes HD44780-style bus writes and keeps a 2x16 DDRAM
// shadow plus display/entry/function state, readable on chip.
// Ports:
//   CLK, RESET        - system clock, asynchronous active-high reset
//   bus               - LCD bus (slave modport), asynchronous to CLK
//   RD_ADDR / RD_DATA - shadow read port (0-15 line 1, 16-31 line 2), 1-cycle latency
//   AC                - DDRAM address counter
//   DISP_ON, CURSOR_ON, BLINK_ON, ENTRY_INC, TWO_LINE - decoded mode bits
//   BUSY              - clear engine running
//   CMD_STB, DATA_STB - one-cycle pulse per accepted command / data write
//   OVERRUN           - sticky: a transaction arrived while BUSY
module lcd_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CLEAR_CHAR  = 8'h20
) (
  input  logic               CLK,
  input  logic               RESET,
  lcd_bus_monitor_if.slave   bus,
  input  logic [4:0]         RD_ADDR,
  output logic [7:0]         RD_DATA,
  output logic [6:0]         AC,
  output logic               DISP_ON,
  output logic               CURSOR_ON,
  output logic               BLINK_ON,
  output logic               ENTRY_INC,
  output logic               TWO_LINE,
  output logic               BUSY,
  output logic               CMD_STB,
  output logic               DATA_STB,
  output logic               OVERRUN
);

  localparam int unsigned BUS_W   = 11;   // {EN, RS, RW, DATA[7:0]}
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned HI_W    = 8;
  localparam int unsigned EN_BIT  = BUS_W - 1;
  localparam int unsigned RS_BIT  = BUS_W - 2;
  localparam int unsigned RW_BIT  = BUS_W - 3;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_e;

  logic [BUS_W-1:0] sync_q [SYNC_STAGES];
  logic [BUS_W-1:0] bus_raw;
  logic [BUS_W-1:0] bus_s;
  logic             en_s;
  logic             en_fall;
  logic [HI_W-1:0]  hi_cnt_q;

  logic             pend_valid_q;
  logic             pend_rs_q;
  logic             pend_rw_q;
  logic [7:0]       pend_data_q;

  clr_state_e       state_q;
  logic [IDX_W-1:0] clr_idx_q;
  logic             cgram_mode_q;

  logic [7:0]       shadow [DEPTH];
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [7:0]       mem_wdata;
  logic             ac_on_screen;
  logic [IDX_W-1:0] ac_idx;

  // Step the address counter, folding the two 40-column DDRAM lines together.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (ac == 7'h27)      r = 7'h40;
      else if (ac == 7'h67) r = 7'h00;
      else                  r = 7'(ac + 7'd1);
    end else begin
      if (ac == 7'h40)      r = 7'h27;
      else if (ac == 7'h00) r = 7'h67;
      else                  r = 7'(ac - 7'd1);
    end
    return r;
  endfunction

  assign bus_raw = {bus.LCM_EN, bus.LCM_RS, bus.LCM_RW, bus.LCM_DATA};
  assign bus_s   = sync_q[SYNC_STAGES-1];
  assign en_s    = bus_s[EN_BIT];

  // A fall only counts once EN has been seen high for SYNC_STAGES cycles,
  // so single-cycle glitches never become transactions.
  assign en_fall = !en_s && (hi_cnt_q >= HI_W'(SYNC_STAGES));

  // Visible window: 0x00-0x0F -> 0-15, 0x40-0x4F -> 16-31.
  assign ac_on_screen = (AC[6:4] == 3'b000) || (AC[6:4] == 3'b100);
  assign ac_idx       = {AC[6], AC[3:0]};

  // Shadow write port: clear engine has priority; data writes never overlap it.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdata = CLEAR_CHAR;
    end else if (pend_valid_q && !pend_rw_q && pend_rs_q && !cgram_mode_q && ac_on_screen) begin
      mem_we    = 1'b1;
      mem_waddr = ac_idx;
      mem_wdata = pend_data_q;
    end
  end

  // Shadow storage; contents are initialised by the clear engine after reset.
  always_ff @(posedge CLK) begin
    if (mem_we) shadow[mem_waddr] <= mem_wdata;
  end

  // Synchronizer, edge capture, decode, clear engine and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hi_cnt_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_rs_q    <= 1'b0;
      pend_rw_q    <= 1'b0;
      pend_data_q  <= '0;
      state_q      <= ST_CLEAR;
      clr_idx_q    <= '0;
      cgram_mode_q <= 1'b0;
      BUSY         <= 1'b1;
      RD_DATA      <= '0;
      AC           <= '0;
      DISP_ON      <= 1'b0;
      CURSOR_ON    <= 1'b0;
      BLINK_ON     <= 1'b0;
      ENTRY_INC    <= 1'b1;
      TWO_LINE     <= 1'b0;
      CMD_STB      <= 1'b0;
      DATA_STB     <= 1'b0;
      OVERRUN      <= 1'b0;
    end else begin
      sync_q[0] <= bus_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];

      if (!en_s)                hi_cnt_q <= '0;
      else if (hi_cnt_q != '1)  hi_cnt_q <= HI_W'(hi_cnt_q + 1'b1);

      // RS/RW/DATA come from the same synced stage as the EN fall.
      pend_valid_q <= en_fall;
      if (en_fall) begin
        pend_rs_q   <= bus_s[RS_BIT];
        pend_rw_q   <= bus_s[RW_BIT];
        pend_data_q <= bus_s[7:0];
      end

      CMD_STB  <= 1'b0;
      DATA_STB <= 1'b0;
      RD_DATA  <= shadow[RD_ADDR];

      if (state_q == ST_CLEAR) begin
        clr_idx_q <= IDX_W'(clr_idx_q + 1'b1);
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_q <= ST_IDLE;
          BUSY    <= 1'b0;
        end
      end

      if (pend_valid_q) begin
        if (state_q == ST_CLEAR) begin
          OVERRUN <= 1'b1;
        end else if (pend_rw_q) begin
          // bus reads carry nothing for the shadow
        end else if (!pend_rs_q) begin
          CMD_STB <= 1'b1;
          casez (pend_data_q)
            8'b1???????: begin
              AC           <= pend_data_q[6:0];
              cgram_mode_q <= 1'b0;
            end
            8'b01??????: cgram_mode_q <= 1'b1;
            8'b001?????: TWO_LINE <= pend_data_q[3];
            8'b0001????: begin
              if (!pend_data_q[3]) AC <= ac_step(AC, pend_data_q[2]);
            end
            8'b00001???: begin
              DISP_ON   <= pend_data_q[2];
              CURSOR_ON <= pend_data_q[1];
              BLINK_ON  <= pend_data_q[0];
            end
            8'b000001??: ENTRY_INC <= pend_data_q[1];
            8'b0000001?: AC <= '0;
            8'b00000001: begin
              AC           <= '0;
              ENTRY_INC    <= 1'b1;
              cgram_mode_q <= 1'b0;
              state_q      <= ST_CLEAR;
              clr_idx_q    <= '0;
              BUSY         <= 1'b1;
            end
            default: ;
          endcase
        end else begin
          DATA_STB <= 1'b1;
          if (!cgram_mode_q) AC <= ac_step(AC, ENTRY_INC);
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed self-checking bench for lcd_bus_monitor.
module tb_lcd_bus_monitor;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] RD_ADDR;
  logic [7:0] RD_DATA;
  logic [6:0] AC;
  logic       DISP_ON, CURSOR_ON, BLINK_ON, ENTRY_INC, TWO_LINE;
  logic       BUSY, CMD_STB, DATA_STB, OVERRUN;

  int checks = 0;
  int errors = 0;
  int cmd_cnt = 0;
  int data_cnt = 0;

  lcd_bus_monitor_if bus_if ();

  lcd_bus_monitor #(.SYNC_STAGES(2), .CLEAR_CHAR(8'h20)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus_if),
    .RD_ADDR   (RD_ADDR),
    .RD_DATA   (RD_DATA),
    .AC        (AC),
    .DISP_ON   (DISP_ON),
    .CURSOR_ON (CURSOR_ON),
    .BLINK_ON  (BLINK_ON),
    .ENTRY_INC (ENTRY_INC),
    .TWO_LINE  (TWO_LINE),
    .BUSY      (BUSY),
    .CMD_STB   (CMD_STB),
    .DATA_STB  (DATA_STB),
    .OVERRUN   (OVERRUN)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (CMD_STB === 1'b1)  cmd_cnt++;
    if (DATA_STB === 1'b1) data_cnt++;
  end

  task automatic bus_pulse(input logic rs, input logic rw, input logic [7:0] d, input int hi);
    @(negedge CLK);
    bus_if.LCM_RS   = rs;
    bus_if.LCM_RW   = rw;
    bus_if.LCM_DATA = d;
    bus_if.LCM_EN   = 1'b1;
    repeat (hi) @(negedge CLK);
    bus_if.LCM_EN   = 1'b0;
  endtask

  task automatic lcd_write(input logic rs, input logic [7:0] d);
    bus_pulse(rs, 1'b0, d, 4);
    repeat (8) @(negedge CLK);
  endtask

  task automatic read_shadow(input logic [4:0] a, output logic [7:0] d);
    @(negedge CLK);
    RD_ADDR = a;
    @(negedge CLK);
    d = RD_DATA;
  endtask

  task automatic test_reset();
    int busy_n;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (RD_DATA !== 8'h00)  begin errors++; $display("FAIL rst_rd_data got %h want %h", RD_DATA, 8'h00); end
    checks++; if (AC !== 7'h00)       begin errors++; $display("FAIL rst_ac got %h want %h", AC, 7'h00); end
    checks++; if ({DISP_ON, CURSOR_ON, BLINK_ON} !== 3'b000) begin errors++; $display("FAIL rst_disp got %b want 000", {DISP_ON, CURSOR_ON, BLINK_ON}); end
    checks++; if (ENTRY_INC !== 1'b1) begin errors++; $display("FAIL rst_entry_inc got %b want 1", ENTRY_INC); end
    checks++; if (TWO_LINE !== 1'b0)  begin errors++; $display("FAIL rst_two_line got %b want 0", TWO_LINE); end
    checks++; if ({CMD_STB, DATA_STB, OVERRUN} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {CMD_STB, DATA_STB, OVERRUN}); end
    RESET = 1'b0;
    busy_n = 0;
    while (BUSY === 1'b1 && busy_n < 100) begin busy_n++; @(negedge CLK); end
    checks++; if (busy_n !== 32) begin errors++; $display("FAIL rst_busy_len got %0d want %0d", busy_n, 32); end
    repeat (8) @(negedge CLK);
  endtask

  task automatic test_latency();
    logic s3, s4, s5;
    int c0;
    c0 = cmd_cnt;
    bus_pulse(1'b0, 1'b0, 8'h00, 4);
    repeat (3) @(negedge CLK);
    s3 = CMD_STB;
    @(negedge CLK); s4 = CMD_STB;
    @(negedge CLK); s5 = CMD_STB;
    checks++; if ({s3, s4, s5} !== 3'b010) begin errors++; $display("FAIL lat_strobe got %b want 010", {s3, s4, s5}); end
    repeat (4) @(negedge CLK);
    checks++; if (cmd_cnt - c0 !== 1) begin errors++; $display("FAIL lat_nop_count got %0d want 1", cmd_cnt - c0); end
    checks++; if (AC !== 7'h00) begin errors++; $display("FAIL lat_nop_ac got %h want %h", AC, 7'h00); end
  endtask

  task automatic test_basic_write();
    int c0, d0;
    logic [7:0] v;
    logic [7:0] exp [4];
    exp[0] = 8'h4C; exp[1] = 8'h43; exp[2] = 8'h44; exp[3] = 8'h20;
    c0 = cmd_cnt; d0 = data_cnt;
    lcd_write(1'b0, 8'h38); lcd_write(1'b0, 8'h0C); lcd_write(1'b0, 8'h06); lcd_write(1'b0, 8'h80);
    lcd_write(1'b1, 8'h4C); lcd_write(1'b1, 8'h43); lcd_write(1'b1, 8'h44);
    for (int i = 0; i < 4; i++) begin
      read_shadow(5'(i), v);
      checks++; if (v !== exp[i]) begin errors++; $display("FAIL basic_shadow%0d got %h want %h", i, v, exp[i]); end
    end
    checks++; if (AC !== 7'h03) begin errors++; $display("FAIL basic_ac got %h want %h", AC, 7'h03); end
    checks++; if ({DISP_ON, CURSOR_ON, BLINK_ON} !== 3'b100) begin errors++; $display("FAIL basic_disp got %b want 100", {DISP_ON, CURSOR_ON, BLINK_ON}); end
    checks++; if ({TWO_LINE, ENTRY_INC} !== 2'b11) begin errors++; $display("FAIL basic_func got %b want 11", {TWO_LINE, ENTRY_INC}); end
    checks++; if (cmd_cnt - c0 !== 4) begin errors++; $display("FAIL basic_cmd_stb got %0d want 4", cmd_cnt - c0); end
    checks++; if (data_cnt - d0 !== 3) begin errors++; $display("FAIL basic_data_stb got %0d want 3", data_cnt - d0); end
  endtask

  task automatic test_line2();
    lcd_write(1'b0, 8'hC0); lcd_write(1'b1, 8'h30); lcd_write(1'b1, 8'h31);
    checks++; if (AC !== 7'h42) begin errors++; $display("FAIL line2_ac got %h want %h", AC, 7'h42); end
    @(negedge CLK); RD_ADDR = 5'd16;
    @(negedge CLK);
    checks++; if (RD_DATA !== 8'h30) begin errors++; $display("FAIL line2_rd16 got %h want %h", RD_DATA, 8'h30); end
    RD_ADDR = 5'd17;
    checks++; if (RD_DATA !== 8'h30) begin errors++; $display("FAIL line2_rd_latency got %h want %h", RD_DATA, 8'h30); end
    @(negedge CLK);
    checks++; if (RD_DATA !== 8'h31) begin errors++; $display("FAIL line2_rd17 got %h want %h", RD_DATA, 8'h31); end
  endtask

  task automatic test_offscreen();
    logic [7:0] v;
    int d0;
    d0 = data_cnt;
    lcd_write(1'b0, 8'h8F); lcd_write(1'b1, 8'h41);
    checks++; if (AC !== 7'h10) begin errors++; $display("FAIL off_ac1 got %h want %h", AC, 7'h10); end
    lcd_write(1'b1, 8'h42);
    checks++; if (AC !== 7'h11) begin errors++; $display("FAIL off_ac2 got %h want %h", AC, 7'h11); end
    lcd_write(1'b0, 8'hA7); lcd_write(1'b1, 8'h58);
    checks++; if (AC !== 7'h40) begin errors++; $display("FAIL off_wrap_ac got %h want %h", AC, 7'h40); end
    checks++; if (data_cnt - d0 !== 3) begin errors++; $display("FAIL off_data_stb got %0d want 3", data_cnt - d0); end
    read_shadow(5'd15, v);
    checks++; if (v !== 8'h41) begin errors++; $display("FAIL off_shadow15 got %h want %h", v, 8'h41); end
    read_shadow(5'd16, v);
    checks++; if (v !== 8'h30) begin errors++; $display("FAIL off_shadow16 got %h want %h", v, 8'h30); end
    read_shadow(5'd0, v);
    checks++; if (v !== 8'h4C) begin errors++; $display("FAIL off_shadow0 got %h want %h", v, 8'h4C); end
  endtask

  task automatic test_decrement_wrap();
    logic [7:0] v;
    lcd_write(1'b0, 8'h04); lcd_write(1'b0, 8'h80); lcd_write(1'b1, 8'h5A);
    checks++; if (ENTRY_INC !== 1'b0) begin errors++; $display("FAIL dec_entry got %b want 0", ENTRY_INC); end
    checks++; if (AC !== 7'h67) begin errors++; $display("FAIL dec_ac got %h want %h", AC, 7'h67); end
    read_shadow(5'd0, v);
    checks++; if (v !== 8'h5A) begin errors++; $display("FAIL dec_shadow0 got %h want %h", v, 8'h5A); end
    lcd_write(1'b0, 8'h14);
    checks++; if (AC !== 7'h00) begin errors++; $display("FAIL inc_wrap_ac got %h want %h", AC, 7'h00); end
  endtask

  task automatic test_cgram_shift();
    logic [7:0] v;
    int d0;
    d0 = data_cnt;
    lcd_write(1'b0, 8'h45); lcd_write(1'b1, 8'h99);
    checks++; if (data_cnt - d0 !== 1) begin errors++; $display("FAIL cg_data_stb got %0d want 1", data_cnt - d0); end
    checks++; if (AC !== 7'h00) begin errors++; $display("FAIL cg_ac got %h want %h", AC, 7'h00); end
    read_shadow(5'd0, v);
    checks++; if (v !== 8'h5A) begin errors++; $display("FAIL cg_shadow0 got %h want %h", v, 8'h5A); end
    lcd_write(1'b0, 8'h18);
    checks++; if (AC !== 7'h00) begin errors++; $display("FAIL dshift_ac got %h want %h", AC, 7'h00); end
    lcd_write(1'b0, 8'h10);
    checks++; if (AC !== 7'h67) begin errors++; $display("FAIL cshift_left_ac got %h want %h", AC, 7'h67); end
    lcd_write(1'b0, 8'h02);
    checks++; if (AC !== 7'h00) begin errors++; $display("FAIL home_ac got %h want %h", AC, 7'h00); end
  endtask

  task automatic test_clear_overrun();
    int c0, d0, busy_n, wait_n;
    logic [7:0] v;
    c0 = cmd_cnt; d0 = data_cnt;
    lcd_write(1'b0, 8'h85);
    bus_pulse(1'b0, 1'b0, 8'h01, 4);
    wait_n = 0;
    while (CMD_STB !== 1'b1 && wait_n < 20) begin @(negedge CLK); wait_n++; end
    checks++; if (CMD_STB !== 1'b1) begin errors++; $display("FAIL clr_stb_timeout got %b want 1", CMD_STB); end
    busy_n = 0;
    fork
      begin
        while (BUSY === 1'b1 && busy_n < 100) begin busy_n++; @(negedge CLK); end
      end
      begin
        repeat (3) @(negedge CLK);
        bus_pulse(1'b1, 1'b0, 8'h41, 4);
      end
    join
    repeat (4) @(negedge CLK);
    checks++; if (busy_n !== 32) begin errors++; $display("FAIL clr_busy_len got %0d want %0d", busy_n, 32); end
    checks++; if (OVERRUN !== 1'b1) begin errors++; $display("FAIL clr_overrun got %b want 1", OVERRUN); end
    checks++; if (data_cnt - d0 !== 0) begin errors++; $display("FAIL clr_no_data_stb got %0d want 0", data_cnt - d0); end
    checks++; if (cmd_cnt - c0 !== 2) begin errors++; $display("FAIL clr_cmd_stb got %0d want 2", cmd_cnt - c0); end
    checks++; if (AC !== 7'h00) begin errors++; $display("FAIL clr_ac got %h want %h", AC, 7'h00); end
    checks++; if (ENTRY_INC !== 1'b1) begin errors++; $display("FAIL clr_entry got %b want 1", ENTRY_INC); end
    for (int i = 0; i < 32; i++) begin
      read_shadow(5'(i), v);
      checks++; if (v !== 8'h20) begin errors++; $display("FAIL clr_shadow%0d got %h want %h", i, v, 8'h20); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_n, wait_n, c0, d0;
    logic [7:0] v;
    lcd_write(1'b0, 8'h80); lcd_write(1'b1, 8'h55); lcd_write(1'b0, 8'h0F);
    read_shadow(5'd0, v);
    checks++; if (v !== 8'h55) begin errors++; $display("FAIL mid_pre_shadow0 got %h want %h", v, 8'h55); end
    checks++; if ({DISP_ON, CURSOR_ON, BLINK_ON} !== 3'b111) begin errors++; $display("FAIL mid_pre_disp got %b want 111", {DISP_ON, CURSOR_ON, BLINK_ON}); end
    bus_pulse(1'b0, 1'b0, 8'h01, 4);
    wait_n = 0;
    while (CMD_STB !== 1'b1 && wait_n < 20) begin @(negedge CLK); wait_n++; end
    checks++; if (CMD_STB !== 1'b1) begin errors++; $display("FAIL mid_stb_timeout got %b want 1", CMD_STB); end
    repeat (10) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    checks++; if ({DISP_ON, CURSOR_ON, BLINK_ON} !== 3'b000) begin errors++; $display("FAIL mid_rst_disp got %b want 000", {DISP_ON, CURSOR_ON, BLINK_ON}); end
    checks++; if ({TWO_LINE, ENTRY_INC} !== 2'b01) begin errors++; $display("FAIL mid_rst_func got %b want 01", {TWO_LINE, ENTRY_INC}); end
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL mid_rst_overrun got %b want 0", OVERRUN); end
    checks++; if (RD_DATA !== 8'h00) begin errors++; $display("FAIL mid_rst_rd_data got %h want %h", RD_DATA, 8'h00); end
    checks++; if (AC !== 7'h00) begin errors++; $display("FAIL mid_rst_ac got %h want %h", AC, 7'h00); end
    RESET = 1'b0;
    busy_n = 0;
    while (BUSY === 1'b1 && busy_n < 100) begin busy_n++; @(negedge CLK); end
    checks++; if (busy_n !== 32) begin errors++; $display("FAIL mid_busy_len got %0d want %0d", busy_n, 32); end
    for (int i = 0; i < 32; i++) begin
      read_shadow(5'(i), v);
      checks++; if (v !== 8'h20) begin errors++; $display("FAIL mid_shadow%0d got %h want %h", i, v, 8'h20); end
    end
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL mid_post_overrun got %b want 0", OVERRUN); end
    c0 = cmd_cnt; d0 = data_cnt;
    bus_pulse(1'b1, 1'b0, 8'h77, 1);
    repeat (10) @(negedge CLK);
    checks++; if (data_cnt - d0 !== 0) begin errors++; $display("FAIL glitch_data_stb got %0d want 0", data_cnt - d0); end
    checks++; if (AC !== 7'h00) begin errors++; $display("FAIL glitch_ac got %h want %h", AC, 7'h00); end
    read_shadow(5'd0, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL glitch_shadow0 got %h want %h", v, 8'h20); end
    bus_pulse(1'b0, 1'b1, 8'h85, 4);
    repeat (10) @(negedge CLK);
    checks++; if (cmd_cnt - c0 !== 0) begin errors++; $display("FAIL read_cycle_cmd_stb got %0d want 0", cmd_cnt - c0); end
    checks++; if (AC !== 7'h00) begin errors++; $display("FAIL read_cycle_ac got %h want %h", AC, 7'h00); end
  endtask

  initial begin
    RESET           = 1'b1;
    RD_ADDR         = 5'd0;
    bus_if.LCM_EN   = 1'b0;
    bus_if.LCM_RS   = 1'b0;
    bus_if.LCM_RW   = 1'b0;
    bus_if.LCM_DATA = 8'h00;
    test_reset();
    test_latency();
    test_basic_write();
    test_line2();
    test_offscreen();
    test_decrement_wrap();
    test_cgram_shift();
    test_clear_overrun();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
